// File: rtl/cv_clk_pkg.sv
// rtl/cv_clk_pkg.sv - shared types, phase constants and helpers for the clock-enable scheduler
package cv_clk_pkg;

  typedef logic [1:0] cv_phase_t;
  typedef logic [7:0] cv_wait_cnt_t;

  localparam cv_phase_t PHASE_P      = 2'd0;
  localparam cv_phase_t PHASE_N      = 2'd2;
  localparam cv_phase_t PHASE_RELOAD = 2'd2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } cv_stall_st_t;

  // Phase runs 0 -> 2 -> 1 -> 0 so the n slot lands one en10 after the p slot.
  function automatic cv_phase_t next_phase(input cv_phase_t p);
    return (p == PHASE_P) ? PHASE_RELOAD : p - 2'd1;
  endfunction

endpackage

// File: rtl/cv_frac_div.sv
// rtl/cv_frac_div.sv - NUM_P/DEN_P fractional accumulator producing the 10.74 MHz enable
module cv_frac_div #(
  parameter int unsigned NUM_P = 1,
  parameter int unsigned DEN_P = 4,
  parameter int unsigned ACC_W = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic hold_i,
  output logic en_o
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic             w_wrap;

  assign w_sum  = r_acc + ACC_W'(NUM_P);
  assign w_wrap = (w_sum >= ACC_W'(DEN_P));
  assign en_o   = w_wrap & ~hold_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_acc <= '0;
    end else if (!hold_i) begin
      r_acc <= w_wrap ? (w_sum - ACC_W'(DEN_P)) : w_sum;
    end
  end

endmodule

// File: rtl/cv_clken_sched.sv
// rtl/cv_clken_sched.sv - 10.74/3.58 MHz enable scheduler with stallable CPU p/n enables
// Optional CV_TURBO_EN adds turbo_i for a 5.37 MHz CPU enable pattern.
module cv_clken_sched
  import cv_clk_pkg::*;
#(
  parameter int unsigned NUM_P    = 1,
  parameter int unsigned DEN_P    = 4,
  parameter int unsigned ACC_W    = 8,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pause_i,
  input  logic wait_req_i,
`ifdef CV_TURBO_EN
  input  logic turbo_i,
`endif
  output logic clk_en_10m7_o,
  output logic clk_en_3m58_p_o,
  output logic clk_en_3m58_n_o,
  output logic cpu_en_p_o,
  output logic cpu_en_n_o,
  output logic stall_o,
  output logic wait_timeout_o
);

  localparam cv_wait_cnt_t WAIT_CNT = cv_wait_cnt_t'(WAIT_MAX);

  logic         w_en10;
  logic         w_p3;
  logic         w_n3;
  logic         w_cpu_p_slot;
  logic         w_cpu_n_slot;
  logic         w_pass;
  logic         w_timeout;
  cv_phase_t    r_phase;
  cv_stall_st_t r_state;
  cv_stall_st_t w_state_nxt;
  cv_wait_cnt_t r_timer;
  cv_wait_cnt_t w_timer_nxt;

  cv_frac_div #(
    .NUM_P(NUM_P),
    .DEN_P(DEN_P),
    .ACC_W(ACC_W)
  ) u_frac_div (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .hold_i (pause_i),
    .en_o   (w_en10)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_phase <= PHASE_P;
    end else if (w_en10) begin
      r_phase <= next_phase(r_phase);
    end
  end

  assign w_p3 = w_en10 & (r_phase == PHASE_P);
  assign w_n3 = w_en10 & (r_phase == PHASE_N);

`ifdef CV_TURBO_EN
  logic r_turbo_q;
  logic r_tog;

  // Mode is only swapped on a 3.58 MHz p slot; the toggle restarts so turbo begins on a p slot.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_turbo_q <= 1'b0;
      r_tog     <= 1'b0;
    end else if (w_p3 && (turbo_i != r_turbo_q)) begin
      r_turbo_q <= turbo_i;
      r_tog     <= 1'b0;
    end else if (r_turbo_q && w_en10) begin
      r_tog     <= ~r_tog;
    end
  end

  assign w_cpu_p_slot = r_turbo_q ? (w_en10 & ~r_tog) : w_p3;
  assign w_cpu_n_slot = r_turbo_q ? (w_en10 &  r_tog) : w_n3;
`else
  assign w_cpu_p_slot = w_p3;
  assign w_cpu_n_slot = w_n3;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_RUN;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Wait requests are sampled only on CPU p slots; a release lets that same p slot through.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pass      = 1'b1;
    w_timeout   = 1'b0;
    if (w_cpu_p_slot) begin
      if (r_state == ST_RUN) begin
        if (wait_req_i) begin
          w_state_nxt = ST_STALL;
          w_timer_nxt = 8'd1;
          w_pass      = 1'b0;
        end
      end else if (!wait_req_i) begin
        w_state_nxt = ST_RUN;
      end else if (r_timer == WAIT_CNT) begin
        w_state_nxt = ST_RUN;
        w_timeout   = 1'b1;
      end else begin
        w_pass = 1'b0;
        if (r_timer != 8'hFF) begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
    end
  end

  assign clk_en_10m7_o   = w_en10;
  assign clk_en_3m58_p_o = w_p3;
  assign clk_en_3m58_n_o = w_n3;
  assign cpu_en_p_o      = w_cpu_p_slot & w_pass;
  assign cpu_en_n_o      = w_cpu_n_slot & (r_state == ST_RUN);
  assign stall_o         = (r_state == ST_STALL);
  assign wait_timeout_o  = w_timeout;

endmodule

// File: tb/tb_cv_clken_sched.sv
// tb/tb_cv_clken_sched.sv - randomized model-checked bench for cv_clken_sched (two parameter sets)
module tb_cv_clken_sched;

  logic clk;
  logic rst;
  logic pause;
  logic wreq;
  logic turbo;

  wire [1:0] en10, p3, n3, cp, cn, st, tmo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cv_clken_sched u_a (
    .clk_i(clk), .reset_i(rst), .pause_i(pause), .wait_req_i(wreq),
`ifdef CV_TURBO_EN
    .turbo_i(turbo),
`endif
    .clk_en_10m7_o(en10[0]), .clk_en_3m58_p_o(p3[0]), .clk_en_3m58_n_o(n3[0]),
    .cpu_en_p_o(cp[0]), .cpu_en_n_o(cn[0]), .stall_o(st[0]), .wait_timeout_o(tmo[0])
  );

  cv_clken_sched #(.NUM_P(3), .DEN_P(8), .ACC_W(8), .WAIT_MAX(4)) u_b (
    .clk_i(clk), .reset_i(rst), .pause_i(pause), .wait_req_i(wreq),
`ifdef CV_TURBO_EN
    .turbo_i(turbo),
`endif
    .clk_en_10m7_o(en10[1]), .clk_en_3m58_p_o(p3[1]), .clk_en_3m58_n_o(n3[1]),
    .cpu_en_p_o(cp[1]), .cpu_en_n_o(cn[1]), .stall_o(st[1]), .wait_timeout_o(tmo[1])
  );

  // Model state: active clock count, en10 count, stalled p slots, turbo mode and toggle.
  typedef struct {
    int act;
    int ecnt;
    int held;
    bit tq;
    bit tog;
  } mdl_t;

  typedef struct {
    bit en10, p3, n3, cp, cn, st, tmo;
    int nh;
  } exp_t;

  mdl_t m [2];
  int   num_c  [2] = '{1, 3};
  int   den_c  [2] = '{4, 8};
  int   wmax_c [2] = '{255, 4};

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  int c_en10[2], c_p3[2], c_n3[2], c_cp[2], c_cn[2], c_st[2], c_tmo[2];
  int mc_en10[2], mc_p3[2];
  bit mp3[2];
  int last_p_a, bad_a, last_e_b, bad_b;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc_n, act, expv);
    end
  endtask

  function automatic exp_t model_out(input int i, input bit pz, input bit wr);
    exp_t e;
    bit cps, cns, pass;
    mdl_t s;
    s = m[i];
    e.en10 = !pz && (((s.act + 1) * num_c[i]) / den_c[i] > (s.act * num_c[i]) / den_c[i]);
    e.p3 = e.en10 && (s.ecnt % 3 == 0);
    e.n3 = e.en10 && (s.ecnt % 3 == 1);
    if (s.tq) begin
      cps = e.en10 && !s.tog;
      cns = e.en10 && s.tog;
    end else begin
      cps = e.p3;
      cns = e.n3;
    end
    pass = 1'b1;
    e.tmo = 1'b0;
    e.nh = s.held;
    if (cps) begin
      if (s.held == 0) begin
        if (wr) begin e.nh = 1; pass = 1'b0; end
      end else if (!wr) begin
        e.nh = 0;
      end else if (s.held == wmax_c[i]) begin
        e.nh = 0; e.tmo = 1'b1;
      end else begin
        pass = 1'b0;
        e.nh = (s.held < 255) ? s.held + 1 : 255;
      end
    end
    e.cp = cps && pass;
    e.cn = cns && (s.held == 0);
    e.st = (s.held != 0);
    return e;
  endfunction

  function automatic mdl_t model_next(input int i, input bit pz, input bit tb, input exp_t e);
    mdl_t s;
    s = m[i];
    if (!pz) s.act++;
    if (e.en10) s.ecnt++;
    s.held = e.nh;
`ifdef CV_TURBO_EN
    if (e.p3 && (tb != s.tq)) begin
      s.tq = tb; s.tog = 1'b0;
    end else if (s.tq && e.en10) begin
      s.tog = !s.tog;
    end
`else
    if (tb && 1'b0) s.tog = 1'b0;
`endif
    return s;
  endfunction

  task automatic clear_counters();
    for (int i = 0; i < 2; i++) begin
      c_en10[i] = 0; c_p3[i] = 0; c_n3[i] = 0; c_cp[i] = 0;
      c_cn[i] = 0; c_st[i] = 0; c_tmo[i] = 0; mc_en10[i] = 0; mc_p3[i] = 0;
    end
    last_p_a = -1; bad_a = 0; last_e_b = -1; bad_b = 0;
  endtask

  // Called at a negedge: drive, settle, compare both DUTs against the model, advance to next negedge.
  task automatic cyc(input bit pz, input bit wr, input bit tb);
    exp_t e;
    pause = pz; wreq = wr; turbo = tb;
    #1;
    for (int i = 0; i < 2; i++) begin
      e = model_out(i, pz, wr);
      chk($sformatf("en10[%0d]", i), int'(en10[i]), int'(e.en10));
      chk($sformatf("p3[%0d]", i),   int'(p3[i]),   int'(e.p3));
      chk($sformatf("n3[%0d]", i),   int'(n3[i]),   int'(e.n3));
      chk($sformatf("cpu_p[%0d]", i), int'(cp[i]),  int'(e.cp));
      chk($sformatf("cpu_n[%0d]", i), int'(cn[i]),  int'(e.cn));
      chk($sformatf("stall[%0d]", i), int'(st[i]),  int'(e.st));
      chk($sformatf("tmo[%0d]", i),  int'(tmo[i]),  int'(e.tmo));
      c_en10[i] += int'(en10[i]); c_p3[i] += int'(p3[i]); c_n3[i] += int'(n3[i]);
      c_cp[i] += int'(cp[i]); c_cn[i] += int'(cn[i]); c_st[i] += int'(st[i]);
      c_tmo[i] += int'(tmo[i]);
      mc_en10[i] += int'(e.en10); mc_p3[i] += int'(e.p3);
      mp3[i] = e.p3;
      m[i] = model_next(i, pz, tb, e);
    end
    if (p3[0]) begin
      if (last_p_a >= 0 && cyc_n - last_p_a != 12) bad_a++;
      last_p_a = cyc_n;
    end
    if (n3[0] && last_p_a >= 0 && cyc_n - last_p_a != 4) bad_a++;
    if (en10[1]) begin
      if (last_e_b >= 0 && cyc_n - last_e_b != 2 && cyc_n - last_e_b != 3) bad_b++;
      last_e_b = cyc_n;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; pause = 1'b0; wreq = 1'b0; turbo = 1'b0;
    #1;
    chk("reset_outs_a", int'({en10[0], p3[0], n3[0], cp[0], cn[0], st[0], tmo[0]}), 0);
    chk("reset_outs_b", int'({en10[1], p3[1], n3[1], cp[1], cn[1], st[1], tmo[1]}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) m[i] = '{act: 0, ecnt: 0, held: 0, tq: 1'b0, tog: 1'b0};
  endtask

  task automatic run_until_p(input int i, input bit wr, input bit tb);
    mp3[i] = 1'b0;
    for (int k = 0; k < 60 && !mp3[i]; k++) cyc(1'b0, wr, tb);
    chk("p_slot_reached", int'(mp3[i]), 1);
  endtask

  initial begin
    int dens;
    bit tb_r;
    rst = 1'b1; pause = 1'b0; wreq = 1'b0; turbo = 1'b0;
    @(negedge clk);
    do_reset();
    clear_counters();

    // Free-running rates on both parameter sets.
    repeat (120) cyc(1'b0, 1'b0, 1'b0);
    chk("a_en10_120", c_en10[0], 30);
    chk("a_p3_120", c_p3[0], 10);
    chk("a_n3_120", c_n3[0], 10);
    chk("a_cpu_p_120", c_cp[0], 10);
    chk("a_cpu_n_120", c_cn[0], 10);
    chk("a_spacing_bad", bad_a, 0);
    repeat (680) cyc(1'b0, 1'b0, 1'b0);
    chk("b_en10_800", c_en10[1], 300);
    chk("b_model_en10_800", mc_en10[1], 300);
    chk("b_gap_bad", bad_b, 0);

    // Wait held across three p slots of instance a.
    run_until_p(0, 1'b0, 1'b0);
    clear_counters();
    for (int k = 0; k < 60 && mc_p3[0] < 3; k++) cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 60 && mc_p3[0] < 4; k++) cyc(1'b0, 1'b0, 1'b0);
    chk("a_stall_clks", c_st[0], 36);
    chk("a_p3_window", c_p3[0], 4);
    chk("a_missing_p", c_p3[0] - c_cp[0], 3);
    chk("a_missing_n", c_n3[0] - c_cn[0], 3);
    chk("a_release_p", c_cp[0], 1);

    // Timeout on instance b with WAIT_MAX=4.
    run_until_p(1, 1'b0, 1'b0);
    clear_counters();
    for (int k = 0; k < 200 && mc_p3[1] < 10; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("b_timeouts", c_tmo[1], 2);
    chk("b_cpu_p_pass", c_cp[1], 2);
    chk("a_no_timeout", c_tmo[0], 0);

    // Pause mid-stall, then reset mid-stall.
    run_until_p(0, 1'b1, 1'b0);
    chk("a_stalled_before_pause", int'(st[0]), 1);
    clear_counters();
    repeat (50) cyc(1'b1, 1'b1, 1'b0);
    chk("pause_enables", c_en10[0] + c_en10[1] + c_cp[0] + c_cp[1] + c_cn[0] + c_cn[1], 0);
    chk("pause_stall_held", c_st[0], 50);
    repeat (30) cyc(1'b0, 1'b1, 1'b0);
    chk("a_stalled_before_reset", int'(st[0]), 1);
    do_reset();

`ifdef CV_TURBO_EN
    repeat (24) cyc(1'b0, 1'b0, 1'b1);
    clear_counters();
    repeat (96) cyc(1'b0, 1'b0, 1'b1);
    chk("turbo_cpu_p", c_cp[0], 12);
    chk("turbo_cpu_n", c_cn[0], 12);
    chk("turbo_p3", c_p3[0], 8);
`endif

    // Randomized traffic.
    tb_r = 1'b0;
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 4))
        0: dens = 0;
        1: dens = 10;
        2: dens = 50;
        3: dens = 90;
        default: dens = 100;
      endcase
      for (int k = 0; k < 200; k++) begin
`ifdef CV_TURBO_EN
        if ($urandom_range(0, 39) == 0) tb_r = !tb_r;
`endif
        if ($urandom_range(0, 1999) == 0) do_reset();
        cyc($urandom_range(0, 15) == 0, $urandom_range(0, 99) < dens, tb_r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
